// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, flush,
// delay-slot tagging and a saturating stall counter. Define PIPE_SKID_EN for a 2-entry skid version.
module pipe_stage_reg #(
    parameter int               WIDTH   = 32*8,
    parameter int               CNT_W   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_branch_ds,
    input  logic [1:0]       in_jump_ds,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_is_ds,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             main_valid_reg;
    logic             main_ds_reg;
    logic [WIDTH-1:0] main_data_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic load;
    logic ds_in;

    assign load  = in_valid && in_ready;
    assign ds_in = (in_branch_ds != 2'b00) || (in_jump_ds != 2'b00);

`ifdef PIPE_SKID_EN
    logic             skid_valid_reg;
    logic             skid_ds_reg;
    logic [WIDTH-1:0] skid_data_reg;

    // Straight from a flop, so out_ready never reaches in_ready combinationally.
    assign in_ready = !skid_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_ds_reg    <= 1'b0;
            main_data_reg  <= RST_VAL;
            skid_valid_reg <= 1'b0;
            skid_ds_reg    <= 1'b0;
            skid_data_reg  <= RST_VAL;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
            main_ds_reg    <= 1'b0;
            main_data_reg  <= RST_VAL;
            skid_valid_reg <= 1'b0;
            skid_ds_reg    <= 1'b0;
            skid_data_reg  <= RST_VAL;
        end else if (main_valid_reg && !out_ready) begin
            if (load) begin
                skid_valid_reg <= 1'b1;
                skid_ds_reg    <= ds_in;
                skid_data_reg  <= in_data;
            end
        end else if (skid_valid_reg) begin
            // Main is draining; in_ready is low, so no new load can race the skid entry.
            main_valid_reg <= 1'b1;
            main_ds_reg    <= skid_ds_reg;
            main_data_reg  <= skid_data_reg;
            skid_valid_reg <= 1'b0;
        end else if (load) begin
            main_valid_reg <= 1'b1;
            main_ds_reg    <= ds_in;
            main_data_reg  <= in_data;
        end else begin
            main_valid_reg <= 1'b0;
        end
    end
`else
    assign in_ready = !main_valid_reg || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_ds_reg    <= 1'b0;
            main_data_reg  <= RST_VAL;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
            main_ds_reg    <= 1'b0;
            main_data_reg  <= RST_VAL;
        end else if (load) begin
            main_valid_reg <= 1'b1;
            main_ds_reg    <= ds_in;
            main_data_reg  <= in_data;
        end else if (out_ready) begin
            main_valid_reg <= 1'b0;
        end
    end
`endif

    // Saturating count of back-pressured cycles; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (main_valid_reg && !out_ready && !flush && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;
    assign out_is_ds = main_ds_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic
// checked against a queue-based model of the stage (capacity 1, or 2 with PIPE_SKID_EN).
module tb_pipe_stage_reg;

    localparam int               WIDTH  = 256;
    localparam int               CNT_W  = 4;
    localparam int               CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [WIDTH-1:0] TB_RST = {8{32'h5EED_0F0F}};
`ifdef PIPE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [1:0]       in_branch_ds = 2'b00;
    logic [1:0]       in_jump_ds = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_is_ds;
    logic [CNT_W-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RST_VAL(TB_RST)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_branch_ds(in_branch_ds), .in_jump_ds(in_jump_ds),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_is_ds(out_is_ds), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of held bundles, last emitted payload, stall count.
    logic [WIDTH-1:0] mq_data[$];
    logic             mq_ds[$];
    logic [WIDTH-1:0] m_last;
    int               m_stall;

    function automatic logic m_in_ready();
        if (DEPTH == 2) return mq_data.size() < 2;
        return (mq_data.size() == 0) || out_ready;
    endfunction

    function automatic logic [WIDTH-1:0] m_out_data();
        if (mq_data.size() > 0) return mq_data[0];
        return m_last;
    endfunction

    function automatic logic [WIDTH-1:0] rand_data();
        logic [WIDTH-1:0] d;
        for (int i = 0; i < WIDTH / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        mq_data.delete();
        mq_ds.delete();
        m_last  = TB_RST;
        m_stall = 0;
    endtask

    // Called right after a rising edge with the inputs that were sampled there.
    task automatic model_step();
        logic xfer;
        xfer = in_valid && m_in_ready();
        if (flush) begin
            mq_data.delete();
            mq_ds.delete();
            m_last = TB_RST;
        end else begin
            if (mq_data.size() > 0) begin
                if (!out_ready) begin
                    if (m_stall < CNT_MAX) m_stall++;
                end else begin
                    m_last = mq_data.pop_front();
                    void'(mq_ds.pop_front());
                end
            end
            if (xfer) begin
                mq_data.push_back(in_data);
                mq_ds.push_back((in_branch_ds != 2'b00) || (in_jump_ds != 2'b00));
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] br,
                         input logic [1:0] jp, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid = v; in_data = d; in_branch_ds = br; in_jump_ds = jp;
        out_ready = ordy; flush = fl;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_branch_ds = 2'b00; in_jump_ds = 2'b00;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] d;
        do_reset();
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== TB_RST || stall_cnt !== '0 || out_is_ds !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: valid=%b ds=%b cnt=%0d data=%h, need 0/0/0 data=%h",
                     out_valid, out_is_ds, stall_cnt, out_data, TB_RST);
        end
        d = rand_data();
        cycle(1'b1, d, 2'b01, 2'b00, 1'b0, 1'b0);
        cycle(1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== d || stall_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_preload: valid=%b cnt=%0d data=%h, need 1/1 data=%h",
                     out_valid, stall_cnt, out_data, d);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== TB_RST || stall_cnt !== '0 || out_is_ds !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b ds=%b cnt=%0d data=%h, need 0/0/0 data=%h",
                     out_valid, out_is_ds, stall_cnt, out_data, TB_RST);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset test done");
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, WIDTH'(i), 2'b00, 2'b00, 1'b1, 1'b0);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'(i)) begin
                n_fail++;
                $display("FAIL stream_%0d: valid=%b data=%0h, need 1 data=%0h", i, out_valid, out_data, i);
            end
        end
        cycle(1'b0, '0, 2'b00, 2'b00, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== WIDTH'(4)) begin
            n_fail++;
            $display("FAIL stream_drain: valid=%b data=%0h, need 0 data=4", out_valid, out_data);
        end
        $display("[TB] stream test done");
    endtask

    task automatic test_stall();
        do_reset();
        cycle(1'b1, WIDTH'(8'hA5), 2'b00, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'(8'hA5)) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: valid=%b data=%0h, need 1 data=a5", i, out_valid, out_data);
            end
        end
        n_tests++;
        if (stall_cnt !== 4'd5) begin
            n_fail++;
            $display("FAIL stall_count: cnt=%0d, need 5", stall_cnt);
        end
        cycle(1'b0, '0, 2'b00, 2'b00, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'd5) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b cnt=%0d, need 0/5", out_valid, stall_cnt);
        end
        $display("[TB] stall test done");
    endtask

    task automatic test_saturate();
        do_reset();
        cycle(1'b1, WIDTH'(7), 2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < CNT_MAX + 6; i++) cycle(1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0);
        n_tests++;
        if (stall_cnt !== CNT_W'(CNT_MAX) || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_saturate: cnt=%0d valid=%b, need %0d/1", stall_cnt, out_valid, CNT_MAX);
        end
        cycle(1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b1);
        n_tests++;
        if (stall_cnt !== CNT_W'(CNT_MAX) || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_after_flush: cnt=%0d valid=%b, need %0d/0", stall_cnt, out_valid, CNT_MAX);
        end
        $display("[TB] saturate test done");
    endtask

`ifdef PIPE_SKID_EN
    task automatic test_skid();
        do_reset();
        cycle(1'b1, WIDTH'(32'hAAAA), 2'b00, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, WIDTH'(32'hBBBB), 2'b01, 2'b00, 1'b0, 1'b0);
        n_tests++;
        if (in_ready !== 1'b0 || out_data !== WIDTH'(32'hAAAA) || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_full: in_ready=%b valid=%b data=%0h, need 0/1 data=aaaa",
                     in_ready, out_valid, out_data);
        end
        cycle(1'b1, WIDTH'(32'hCCCC), 2'b00, 2'b00, 1'b0, 1'b0);
        cycle(1'b0, '0, 2'b00, 2'b00, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== WIDTH'(32'hBBBB) || out_is_ds !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_release: valid=%b ds=%b in_ready=%b data=%0h, need 1/1/1 data=bbbb",
                     out_valid, out_is_ds, in_ready, out_data);
        end
        cycle(1'b0, '0, 2'b00, 2'b00, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL skid_empty: valid=%b, need 0", out_valid);
        end
        $display("[TB] skid test done");
    endtask
`endif

    task automatic test_flush();
        do_reset();
        cycle(1'b1, WIDTH'(32'h1111), 2'b10, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, WIDTH'(32'hC0C0), 2'b00, 2'b01, 1'b1, 1'b1);
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== TB_RST || out_is_ds !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: valid=%b ds=%b data=%h, need 0/0 data=%h",
                     out_valid, out_is_ds, out_data, TB_RST);
        end
        cycle(1'b0, '0, 2'b00, 2'b00, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== TB_RST) begin
            n_fail++;
            $display("FAIL flush_discard: valid=%b data=%h, need 0 data=%h", out_valid, out_data, TB_RST);
        end
        $display("[TB] flush test done");
    endtask

    task automatic test_delay_slot();
        logic [1:0] br [4] = '{2'b01, 2'b00, 2'b00, 2'b00};
        logic [1:0] jp [4] = '{2'b00, 2'b00, 2'b10, 2'b00};
        logic       ex [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, WIDTH'(32'hD000 + i), br[i], jp[i], 1'b1, 1'b0);
            n_tests++;
            if (out_is_ds !== ex[i] || out_data !== WIDTH'(32'hD000 + i)) begin
                n_fail++;
                $display("FAIL delay_slot_%0d: ds=%b data=%0h, need %b data=%0h",
                         i, out_is_ds, out_data, ex[i], 32'hD000 + i);
            end
        end
        $display("[TB] delay slot test done");
    endtask

    task automatic test_random();
        int fails_before;
        fails_before = n_fail;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid     = ($urandom_range(0, 9) < 7);
            in_data      = rand_data();
            in_branch_ds = $urandom_range(0, 1) ? 2'b00 : 2'($urandom_range(1, 3));
            in_jump_ds   = $urandom_range(0, 1) ? 2'b00 : 2'($urandom_range(1, 3));
            out_ready    = ($urandom_range(0, 9) < 5);
            flush        = ($urandom_range(0, 39) == 0);
            #1;
            n_tests++;
            if (in_ready !== m_in_ready()) begin
                n_fail++;
                $display("FAIL rand_in_ready c=%0d: got %b, need %b", c, in_ready, m_in_ready());
            end
            @(posedge clk);
            model_step();
            #1;
            n_tests++;
            if (out_valid !== (mq_data.size() > 0) || out_data !== m_out_data()
                || stall_cnt !== CNT_W'(m_stall)) begin
                n_fail++;
                $display("FAIL rand_out c=%0d: valid=%b cnt=%0d data=%h, need %b/%0d data=%h",
                         c, out_valid, stall_cnt, out_data, (mq_data.size() > 0), m_stall, m_out_data());
            end
            if (mq_data.size() > 0) begin
                n_tests++;
                if (out_is_ds !== mq_ds[0]) begin
                    n_fail++;
                    $display("FAIL rand_ds c=%0d: got %b, need %b", c, out_is_ds, mq_ds[0]);
                end
            end
        end
        $display("[TB] random test done, %0d new failures", n_fail - fails_before);
    endtask

    initial begin
        model_reset();
        #2 rst = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_saturate();
`ifdef PIPE_SKID_EN
        test_skid();
`endif
        test_flush();
        test_delay_slot();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
